// File: rtl/quad_pkg.sv
// Shared encodings and transition helpers for the quadrature decoder.
package quad_pkg;
  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S10 = 2'b10;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S01 = 2'b01;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int FILTER_LEN = 3;

  // Forward order is 00 -> 10 -> 11 -> 01 -> 00; reverse is the same table swapped.
  function automatic logic is_fwd(input logic [1:0] p, input logic [1:0] c);
    return (p == S00 && c == S10) || (p == S10 && c == S11) ||
           (p == S11 && c == S01) || (p == S01 && c == S00);
  endfunction
endpackage

// File: rtl/quad_decoder_sync_ff.sv
// Single-bit multi-flop synchronizer, async active-high reset to 0.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sr <= '0;
    else       sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];
endmodule

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder with direction, step/error strobes and wrapping count.
// Define QUAD_GLITCH_FILTER_EN to add a FILTER_LEN-cycle stability filter after the synchronizers.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             up_down,
  output logic             step,
  output logic             error
);
  logic       a_s, b_s;
  logic [1:0] sync_ab, cur_ab, prev_ab;
  logic       primed;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_a (.clk(clk), .reset(reset), .d(enc_a), .q(a_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_b (.clk(clk), .reset(reset), .d(enc_b), .q(b_s));

  assign sync_ab = {a_s, b_s};

`ifdef QUAD_GLITCH_FILTER_EN
  // cur_ab follows the synchronized pair only once the current sample and the
  // previous FILTER_LEN-1 samples agree; otherwise it holds its last value.
  logic [FILTER_LEN-2:0][1:0] hist;
  logic [1:0]                 held;
  logic                       stable;

  always_comb begin
    stable = 1'b1;
    for (int i = 0; i < FILTER_LEN-1; i++)
      if (hist[i] != sync_ab) stable = 1'b0;
    cur_ab = stable ? sync_ab : held;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= '0;
      held <= S00;
    end else begin
      hist <= {hist[FILTER_LEN-3:0], sync_ab};
      held <= cur_ab;
    end
  end
`else
  assign cur_ab = sync_ab;
`endif

  logic fwd, rev, bad;

  assign fwd = is_fwd(prev_ab, cur_ab);
  assign rev = is_fwd(cur_ab, prev_ab);
  assign bad = (prev_ab ^ cur_ab) == 2'b11;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      up_down <= DIR_UP;
      step    <= 1'b0;
      error   <= 1'b0;
      prev_ab <= S00;
      primed  <= 1'b0;
    end else begin
      step    <= 1'b0;
      error   <= 1'b0;
      prev_ab <= cur_ab;
      if (!primed) begin
        primed <= 1'b1;
      end else if (fwd) begin
        step    <= 1'b1;
        up_down <= DIR_UP;
        count   <= count + 1'b1;
      end else if (rev) begin
        step    <= 1'b1;
        up_down <= DIR_DOWN;
        count   <= count - 1'b1;
      end else if (bad) begin
        error   <= 1'b1;
      end
      // clear wins over the count update but leaves the strobes and direction alone
      if (clear) count <= '0;
    end
  end
endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: directed pin sequences push expected events, a negedge monitor checks them.
module tb_quad_decoder;
  localparam int WIDTH = 4;
  localparam int SYNC  = 2;
`ifdef QUAD_GLITCH_FILTER_EN
  localparam int LAT = SYNC + 3;
`else
  localparam int LAT = SYNC + 1;
`endif

  localparam logic [1:0] P00 = 2'b00, P10 = 2'b10, P11 = 2'b11, P01 = 2'b01;

  typedef struct packed {
    int         cyc;
    logic       stp;
    logic       err;
    logic       up;
    logic [3:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             enc_a, enc_b, clear;
  logic [WIDTH-1:0] count;
  logic             up_down, step, error;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  quad_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
    .count(count), .up_down(up_down), .step(step), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every step/error strobe must match the oldest expectation, including its landing cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (step || error) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event cyc=%0d step=%0b err=%0b up=%0b cnt=%0d",
                   cyc, step, error, up_down, count);
        end else begin
          e = q.pop_front();
          if (cyc != e.cyc || step != e.stp || error != e.err ||
              up_down != e.up || count != e.cnt) begin
            failures++;
            $display("FAIL event got cyc=%0d step=%0b err=%0b up=%0b cnt=%0d exp cyc=%0d step=%0b err=%0b up=%0b cnt=%0d",
                     cyc, step, error, up_down, count, e.cyc, e.stp, e.err, e.up, e.cnt);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Drive a new AB pair and queue the decode it should produce LAT clocks later.
  // With clr set, clear is pulsed exactly on the edge that registers this decode.
  task automatic apply(input logic [1:0] ab, input logic s, input logic e,
                       input logic u, input logic [3:0] c, input bit clr);
    enc_a = ab[1];
    enc_b = ab[0];
    q.push_back('{cyc: cyc + LAT, stp: s, err: e, up: u, cnt: c});
    if (clr) begin
      repeat (LAT-1) @(posedge clk);
      #1 clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end else begin
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [1:0] fseq [4];
    fseq[0] = P10; fseq[1] = P11; fseq[2] = P01; fseq[3] = P00;

    reset = 1'b1; enc_a = 1'b1; enc_b = 1'b1; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_up", up_down, 1);
    chk("rst_step", step, 0);
    chk("rst_err", error, 0);

    // Synchronizers restart at 0, so priming captures 00 and the pins' 11 then shows up as illegal.
    reset = 1'b0;
    q.push_back('{cyc: cyc + LAT, stp: 1'b0, err: 1'b1, up: 1'b1, cnt: 4'd0});
    repeat (10) @(posedge clk);
    #1;
    chk("prime_count", count, 0);
    chk("prime_up", up_down, 1);

    apply(P00, 0, 1, 1, 4'd0, 0);

    // 17 forward steps, wrapping 15 -> 0 -> 1
    for (int k = 1; k <= 17; k++) apply(fseq[(k-1) % 4], 1, 0, 1, 4'(k), 0);

    // reverse: 10->00->01->11->10, wrapping below zero
    apply(P00, 1, 0, 0, 4'd0, 0);
    apply(P01, 1, 0, 0, 4'd15, 0);
    apply(P11, 1, 0, 0, 4'd14, 0);
    apply(P10, 1, 0, 0, 4'd13, 0);
    // illegal 10->01 holds count and the down direction
    apply(P01, 0, 1, 0, 4'd13, 0);

    apply(P00, 1, 0, 1, 4'd14, 0);
    apply(P10, 1, 0, 1, 4'd15, 0);
    apply(P11, 1, 0, 1, 4'd0, 0);
    apply(P01, 1, 0, 1, 4'd1, 0);
    apply(P00, 1, 0, 1, 4'd2, 0);
    // illegal 00->11, then 11->01 resumes counting
    apply(P11, 0, 1, 1, 4'd2, 0);
    apply(P01, 1, 0, 1, 4'd3, 0);

    apply(P00, 1, 0, 1, 4'd4, 0);
    apply(P10, 1, 0, 1, 4'd5, 0);
    apply(P11, 1, 0, 1, 4'd6, 0);
    apply(P01, 1, 0, 1, 4'd7, 0);
    // forward step at count 7 collides with clear
    apply(P00, 1, 0, 1, 4'd0, 1);
    apply(P10, 1, 0, 1, 4'd1, 0);

`ifdef QUAD_GLITCH_FILTER_EN
    // 2-clock dip on A must be swallowed entirely
    enc_a = 1'b0;
    repeat (2) @(posedge clk);
    #1 enc_a = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("glitch_count", count, 1);
`endif

    apply(P00, 1, 0, 0, 4'd0, 0);
    apply(P01, 1, 0, 0, 4'd15, 0);
    repeat (6) @(posedge clk);
    #1;

    // async reset mid-operation
    reset = 1'b1; enc_a = 1'b0; enc_b = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_up", up_down, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rerst_count", count, 0);
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d pending=%0d", cyc, q.size());
    $fatal(1, "timeout");
  end
endmodule
